// File: rtl/complex_alu_sequencer.sv
// Complex-number ALU: single-cycle add/sub/conj, four-step shared-multiplier complex multiply.
// Define COMPLEX_SAT_EN to clamp result components instead of wrapping them.
module complex_alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  alu_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

`ifdef COMPLEX_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [4:0] OP_ADD  = 5'b10011;
  localparam logic [4:0] OP_SUB  = 5'b10100;
  localparam logic [4:0] OP_MUL  = 5'b10101;
  localparam logic [4:0] OP_CONJ = 5'b11000;

  typedef enum logic [2:0] {
    S_IDLE, S_M_AC, S_M_BD, S_M_AD, S_M_BC, S_DONE
  } state_t;

  state_t             r_state;
  logic        [31:0] r_a;
  logic        [31:0] r_b;
  logic signed [32:0] r_acc_re;
  logic signed [32:0] r_acc_im;

  // Reduce an exact value to a 16-bit component: clamp or two's-complement wrap.
  function automatic logic [15:0] f_fmt(input logic signed [32:0] v);
    logic [15:0] o;
    o = v[15:0];
    if (SAT_EN) begin
      if (v > 33'sd32767)
        o = 16'h7FFF;
      else if (v < -33'sd32768)
        o = 16'h8000;
    end
    return o;
  endfunction

  function automatic logic signed [32:0] f_ext(input logic [15:0] x);
    return {{17{x[15]}}, x};
  endfunction

  logic signed [32:0] w_in_ar, w_in_ai, w_in_br, w_in_bi;
  logic        [31:0] w_sc_res;
  logic               w_sc_err;

  assign w_in_ar = f_ext(op_a[31:16]);
  assign w_in_ai = f_ext(op_a[15:0]);
  assign w_in_br = f_ext(op_b[31:16]);
  assign w_in_bi = f_ext(op_b[15:0]);

  always_comb begin
    w_sc_res = '0;
    w_sc_err = 1'b0;
    case (alu_op)
      OP_ADD:  w_sc_res = {f_fmt(w_in_ar + w_in_br), f_fmt(w_in_ai + w_in_bi)};
      OP_SUB:  w_sc_res = {f_fmt(w_in_ar - w_in_br), f_fmt(w_in_ai - w_in_bi)};
      OP_CONJ: w_sc_res = {f_fmt(w_in_ar), f_fmt(-w_in_ai)};
      default: w_sc_err = 1'b1;
    endcase
  end

  // Operand select for the single shared multiplier, driven by the multiply step.
  logic signed [15:0] w_mul_x, w_mul_y;
  logic signed [31:0] w_prod;
  logic signed [32:0] w_prod_x;
  logic signed [32:0] w_im_fin;

  always_comb begin
    w_mul_x = r_a[31:16];
    w_mul_y = r_b[31:16];
    case (r_state)
      S_M_BD: begin w_mul_x = r_a[15:0];  w_mul_y = r_b[15:0];  end
      S_M_AD: begin w_mul_x = r_a[31:16]; w_mul_y = r_b[15:0];  end
      S_M_BC: begin w_mul_x = r_a[15:0];  w_mul_y = r_b[31:16]; end
      default: begin w_mul_x = r_a[31:16]; w_mul_y = r_b[31:16]; end
    endcase
  end

  assign w_prod   = w_mul_x * w_mul_y;
  assign w_prod_x = {w_prod[31], w_prod};
  assign w_im_fin = r_acc_im + w_prod_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a  <= op_a;
            r_b  <= op_b;
            busy <= 1'b1;
            if (alu_op == OP_MUL) begin
              err     <= 1'b0;
              r_state <= S_M_AC;
            end else begin
              result  <= w_sc_res;
              err     <= w_sc_err;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_M_AC: begin
          r_acc_re <= w_prod_x;
          r_state  <= S_M_BD;
        end
        S_M_BD: begin
          r_acc_re <= r_acc_re - w_prod_x;
          r_state  <= S_M_AD;
        end
        S_M_AD: begin
          r_acc_im <= w_prod_x;
          r_state  <= S_M_BC;
        end
        S_M_BC: begin
          r_acc_im <= w_im_fin;
          result   <= {f_fmt(r_acc_re), f_fmt(w_im_fin)};
          done     <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
